mcu_port_bank: RTL and testbench

- Parametrised successor to the four fixed 8-bit P0–P3 port SFRs: one block holds NPORTS quasi-bidirectional ports of WIDTH bits each.
- Adds per-port input synchronisers, latch-versus-pin read selection for read-modify-write, and falling-edge capture flags with a masked interrupt.
- Sits on the internal SFR bus between the control unit and the package pins.
- Replaces the per-port oe/en/src/re strobes with address-decoded access.

---
 rtl/mcu51_pkg.sv | 30 +++
 rtl/port_slice.sv | 81 ++++++++
 rtl/mcu_port_bank.sv | 119 +++++++++++
 tb/tb_mcu_port_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu51_pkg.sv
// Shared constants and types for the MCU port-bank SFR block.
// Addresses here match the classic P0..P3 map.
package mcu51_pkg;

  localparam logic [7:0] P0_ADDR = 8'h80;
  localparam logic [7:0] P1_ADDR = 8'h90;
  localparam logic [7:0] P2_ADDR = 8'hA0;
  localparam logic [7:0] P3_ADDR = 8'hB0;

  localparam logic [7:0] MASK_OFS_DEF = 8'h01;
  localparam logic [7:0] FLAG_OFS_DEF = 8'h02;

  typedef enum logic [1:0] {
    SEL_LATCH,
    SEL_MASK,
    SEL_FLAG,
    SEL_NONE
  } port_sel_e;

  function automatic logic [7:0] port_base(
    input logic [7:0] base,
    input logic [7:0] stride,
    input int         idx
  );
    logic [7:0] i8;
    i8 = idx[7:0];
    return base + stride * i8;
  endfunction

endpackage

// File: rtl/port_slice.sv
// One quasi-bidirectional port: pin synchroniser, falling-edge
// flags, and latch/mask/flag registers with byte or bit writes.
module port_slice
  import mcu51_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  port_sel_e        sel,
  input  logic             Bb,
  input  logic [WIDTH-1:0] position,
  input  logic [WIDTH-1:0] din,
  input  logic             bin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] latch,
  output logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] flag,
  output logic [WIDTH-1:0] sync
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] fclr;

  assign fall  = prev_q & ~sync_q[SYNC_STAGES-1];
  assign wmask = Bb ? '1 : position;
  assign wval  = Bb ? din : {WIDTH{bin}};
  // Clear bits for W1C; a bit write with bin=0 clears nothing.
  assign fclr  = wmask & wval;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
    prev_d  = sync_q[SYNC_STAGES-1];
    latch_d = latch_q;
    mask_d  = mask_q;
    flag_d  = flag_q;
    if (we) begin
      unique case (sel)
        SEL_LATCH:
          latch_d = (latch_q & ~wmask) | (wval & wmask);
        SEL_MASK:
          mask_d = (mask_q & ~wmask) | (wval & wmask);
        SEL_FLAG:
          flag_d = flag_q & ~fclr;
        default: ;
      endcase
    end
    flag_d = flag_d | fall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      prev_q  <= '1;
      latch_q <= '1;
      mask_q  <= '0;
      flag_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      latch_q <= latch_d;
      mask_q  <= mask_d;
      flag_q  <= flag_d;
    end
  end

  assign latch = latch_q;
  assign mask  = mask_q;
  assign flag  = flag_q;
  assign sync  = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_port_bank.sv
// Bank of NPORTS quasi-bidirectional ports on the SFR bus:
// address decode, registered read path and interrupt reduction.
module mcu_port_bank
  import mcu51_pkg::*;
#(
  parameter int         NPORTS      = 4,
  parameter int         WIDTH       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BASE_ADDR   = P0_ADDR,
  parameter logic [7:0] STRIDE      = 8'h10,
  parameter logic [7:0] MASK_OFS    = MASK_OFS_DEF,
  parameter logic [7:0] FLAG_OFS    = FLAG_OFS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              addr,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic                    rmw,
  input  logic                    Bb,
  input  logic [WIDTH-1:0]        position,
  input  logic [WIDTH-1:0]        din,
  input  logic                    bin,
  output logic [WIDTH-1:0]        dout,
  output logic                    bout,
  output logic                    rd_valid,
  input  logic [NPORTS*WIDTH-1:0] pin_in,
  output logic [NPORTS*WIDTH-1:0] pin_oe,
  output logic                    irq
);

  port_sel_e psel [NPORTS];

  logic [NPORTS-1:0][WIDTH-1:0] latch;
  logic [NPORTS-1:0][WIDTH-1:0] mask;
  logic [NPORTS-1:0][WIDTH-1:0] flag;
  logic [NPORTS-1:0][WIDTH-1:0] sync;

  logic [WIDTH-1:0] rd_byte;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
  logic             rd_valid_q, rd_valid_d;
  logic             irq_q, irq_d;

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NPORTS; i++) begin
      psel[i] = SEL_NONE;
      unique case (1'b1)
        (addr == port_base(BASE_ADDR, STRIDE, i)):
          psel[i] = SEL_LATCH;
        (addr == port_base(BASE_ADDR, STRIDE, i) + MASK_OFS):
          psel[i] = SEL_MASK;
        (addr == port_base(BASE_ADDR, STRIDE, i) + FLAG_OFS):
          psel[i] = SEL_FLAG;
        default:
          psel[i] = SEL_NONE;
      endcase
      case (psel[i])
        SEL_LATCH: rd_byte = rmw ? latch[i] : sync[i];
        SEL_MASK:  rd_byte = mask[i];
        SEL_FLAG:  rd_byte = flag[i];
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    port_slice #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_slice (
      .clk      (clk),
      .reset    (reset),
      .we       (wr_en),
      .sel      (psel[g]),
      .Bb       (Bb),
      .position (position),
      .din      (din),
      .bin      (bin),
      .pin      (pin_in[g*WIDTH +: WIDTH]),
      .latch    (latch[g]),
      .mask     (mask[g]),
      .flag     (flag[g]),
      .sync     (sync[g])
    );
    assign pin_oe[g*WIDTH +: WIDTH] = ~latch[g];
  end

  always_comb begin
    dout_d     = rd_en ? rd_byte : dout_q;
    bout_d     = rd_en ? |(rd_byte & position) : bout_q;
    rd_valid_d = rd_en;
    irq_d      = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      irq_d = irq_d | (|(flag[i] & mask[i]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q     <= '0;
      bout_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      bout_q     <= bout_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign dout     = dout_q;
  assign bout     = bout_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mcu_port_bank.sv
// Bench for mcu_port_bank: reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_mcu_port_bank;

  localparam int NP = 4;
  localparam int S  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        rmw = 1'b0;
  logic        Bb = 1'b1;
  logic [7:0]  position = '0;
  logic [7:0]  din = '0;
  logic        bin = 1'b0;
  logic [7:0]  dout;
  logic        bout;
  logic        rd_valid;
  logic [31:0] pin_in = '1;
  logic [31:0] pin_oe;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mcu_port_bank dut (
    .clk      (clk),
    .reset    (rst_n),
    .addr     (addr),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rmw      (rmw),
    .Bb       (Bb),
    .position (position),
    .din      (din),
    .bin      (bin),
    .dout     (dout),
    .bout     (bout),
    .rd_valid (rd_valid),
    .pin_in   (pin_in),
    .pin_oe   (pin_oe),
    .irq      (irq)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: pins seen through an S-cycle delay line,
  // registers updated by the bus rules, outputs one cycle late.
  logic [31:0] hist [0:S];
  logic [7:0]  m_latch [NP];
  logic [7:0]  m_mask  [NP];
  logic [7:0]  m_flag  [NP];
  logic [7:0]  e_dout;
  logic        e_bout;
  logic        e_valid;
  logic        e_irq;

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] fall;
    logic [7:0]  rb;
    logic        hit;
    logic        v;
    int          p;
    int          r;
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) hist[k] = '1;
      for (int i = 0; i < NP; i++) begin
        m_latch[i] = 8'hFF;
        m_mask[i]  = 8'h00;
        m_flag[i]  = 8'h00;
      end
      e_dout = 8'h00; e_bout = 1'b0;
      e_valid = 1'b0; e_irq = 1'b0;
    end else begin
      fall = hist[S] & ~hist[S-1];
      e_irq = 1'b0;
      for (int i = 0; i < NP; i++)
        e_irq = e_irq | (|(m_flag[i] & m_mask[i]));
      p = addr[7:4];
      p = p - 8;
      r = addr[3:0];
      hit = (p >= 0) && (p < NP) && (r <= 2);
      if (rd_en) begin
        rb = 8'h00;
        if (hit) begin
          case (r)
            0: rb = rmw ? m_latch[p] : hist[S-1][p*8 +: 8];
            1: rb = m_mask[p];
            default: rb = m_flag[p];
          endcase
        end
        e_dout = rb;
        e_bout = |(rb & position);
        e_valid = 1'b1;
      end else begin
        e_valid = 1'b0;
      end
      if (wr_en && hit) begin
        for (int b = 0; b < 8; b++) begin
          if (Bb || position[b]) begin
            v = Bb ? din[b] : bin;
            case (r)
              0: m_latch[p][b] = v;
              1: m_mask[p][b] = v;
              default: if (v) m_flag[p][b] = 1'b0;
            endcase
          end
        end
      end
      for (int i = 0; i < NP; i++)
        m_flag[i] = m_flag[i] | fall[i*8 +: 8];
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pin_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_pin_oe", pin_oe,
          ~{m_latch[3], m_latch[2], m_latch[1], m_latch[0]});
      chk("m_irq", {31'b0, irq}, {31'b0, e_irq});
      chk("m_rd_valid", {31'b0, rd_valid}, {31'b0, e_valid});
      chk("m_dout", {24'b0, dout}, {24'b0, e_dout});
      chk("m_bout", {31'b0, bout}, {31'b0, e_bout});
    end
  end

  task automatic wr(input logic [7:0] a, input logic byte_m,
                    input logic [7:0] d, input logic [7:0] pos,
                    input logic b);
    addr = a; Bb = byte_m; din = d;
    position = pos; bin = b; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic rm,
                    input logic byte_m, input logic [7:0] pos);
    addr = a; rmw = rm; Bb = byte_m;
    position = pos; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pin_oe", pin_oe, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd(8'h80, 1'b1, 1'b1, 8'h00);
    chk("rd80", {24'b0, dout}, 32'hFF);
    chk("rd80_valid", {31'b0, rd_valid}, 32'h1);

    wr(8'h90, 1'b1, 8'h5A, 8'h00, 1'b0);
    chk("p1_oe", {24'b0, pin_oe[15:8]}, 32'hA5);
    rd(8'h90, 1'b1, 1'b1, 8'h00);
    chk("rd90_latch", {24'b0, dout}, 32'h5A);
    pin_in[15:8] = 8'h0F;
    repeat (3) @(negedge clk);
    rd(8'h90, 1'b0, 1'b1, 8'h00);
    chk("rd90_pins", {24'b0, dout}, 32'h0F);

    wr(8'hA0, 1'b0, 8'h00, 8'h08, 1'b0);
    chk("p2_oe", {24'b0, pin_oe[23:16]}, 32'h08);
    wr(8'hA0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("p2_oe_pos0", {24'b0, pin_oe[23:16]}, 32'h08);
    rd(8'hA0, 1'b1, 1'b1, 8'h00);
    chk("rdA0", {24'b0, dout}, 32'hF7);
    rd(8'hA0, 1'b1, 1'b0, 8'h08);
    chk("bitrd_b3", {31'b0, bout}, 32'h0);
    rd(8'hA0, 1'b1, 1'b0, 8'h01);
    chk("bitrd_b0", {31'b0, bout}, 32'h1);

    wr(8'hB1, 1'b1, 8'h01, 8'h00, 1'b0);
    pin_in[24] = 1'b0;
    repeat (3) @(negedge clk);
    chk("irq_early", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'h1);
    rd(8'hB2, 1'b1, 1'b1, 8'h00);
    chk("rdB2", {24'b0, dout}, 32'h01);
    wr(8'hB2, 1'b1, 8'h01, 8'h00, 1'b0);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_clr", {31'b0, irq}, 32'h0);

    pin_in[24] = 1'b1;
    repeat (4) @(negedge clk);
    pin_in[24] = 1'b0;
    repeat (2) @(negedge clk);
    wr(8'hB2, 1'b1, 8'h01, 8'h00, 1'b0);
    @(negedge clk);
    chk("irq_setwins", {31'b0, irq}, 32'h1);
    rd(8'hB2, 1'b1, 1'b1, 8'h00);
    chk("flag_setwins", {24'b0, dout}, 32'h01);

    wr(8'hB1, 1'b1, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("irq_unmask", {31'b0, irq}, 32'h0);
    wr(8'hB1, 1'b1, 8'h01, 8'h00, 1'b0);
    wr(8'h80, 1'b1, 8'h00, 8'h00, 1'b0);
    wr(8'hB0, 1'b1, 8'h33, 8'h00, 1'b0);
    @(negedge clk);
    chk("irq_rearm", {31'b0, irq}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", pin_oe, 32'h0);
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(8'h80, 1'b1, 1'b1, 8'h00);
    chk("rd80_after", {24'b0, dout}, 32'hFF);
    rd(8'h85, 1'b1, 1'b1, 8'h00);
    chk("rd85", {24'b0, dout}, 32'h00);
    chk("rd85_valid", {31'b0, rd_valid}, 32'h1);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
